// File: rtl/dmem_resp.sv
// Data-memory responder: one byte/half/word load or store per handshake on a little-endian word RAM.
// Define DMEM_SPLIT_EN to split misaligned half/word accesses into two consecutive word accesses.
module dmem_resp #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              mem_wr_i,
    input  logic [1:0]        rwtype_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_i,
    output logic              rsp_valid_o,
    output logic [31:0]       data_o,
    output logic              err_o
);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RSP  = 2'd3
    } state_e;

    function automatic logic [3:0] size_be(input logic [1:0] rwtype);
        case (rwtype)
            2'b00:   size_be = 4'b0001;
            2'b01:   size_be = 4'b0011;
            2'b10:   size_be = 4'b1111;
            default: size_be = 4'b0000;
        endcase
    endfunction

    // Byte enables across the addressed word (low nibble) and the following word (high nibble).
    function automatic logic [7:0] span_be(input logic [1:0] rwtype, input logic [1:0] off);
        span_be = {4'b0000, size_be(rwtype)} << off;
    endfunction

    function automatic logic misaligned(input logic [1:0] rwtype, input logic [1:0] off);
        logic [7:0] span;
        span = span_be(rwtype, off);
        misaligned = |span[7:4];
    endfunction

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                bad_q, bad_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                ready_q, ready_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH];
    logic                acc_hi;
    logic                acc;
    logic                mem_we;
    logic [7:0]          be_wide;
    logic [63:0]         wdata_wide;
    logic [3:0]          lane_be;
    logic [31:0]         lane_wdata;
    logic [WORD_W-1:0]   mem_idx;
    logic [31:0]         mem_rdata;

    // Lane/word selection for the current access; ACC1 targets the next word with wrap.
    always_comb begin
        acc_hi     = (state_q == ACC1);
        be_wide    = span_be(type_q, addr_q[1:0]);
        wdata_wide = {32'h0000_0000, wdata_q} << {addr_q[1:0], 3'b000};
        lane_be    = acc_hi ? be_wide[7:4] : be_wide[3:0];
        lane_wdata = acc_hi ? wdata_wide[63:32] : wdata_wide[31:0];
        mem_idx    = addr_q[ADDR_W-1:2] + WORD_W'(acc_hi);
        mem_rdata  = mem_q[mem_idx];
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bad_d       = bad_q;
        data_d      = data_q;
        err_d       = err_q;
        acc         = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    wr_d    = mem_wr_i;
                    type_d  = rwtype_i;
                    addr_d  = data_addr_i;
                    wdata_d = data_i;
                    rdata_d = '0;
                    bad_d   = (rwtype_i == 2'b11);
`ifndef DMEM_SPLIT_EN
                    if (misaligned(rwtype_i, data_addr_i[1:0])) begin
                        bad_d = 1'b1;
                    end
`endif
                    state_d = bad_d ? RSP : ACC0;
                end
            end
            ACC0: begin
                acc = 1'b1;
`ifdef DMEM_SPLIT_EN
                state_d = misaligned(type_q, addr_q[1:0]) ? ACC1 : RSP;
`else
                state_d = RSP;
`endif
            end
`ifdef DMEM_SPLIT_EN
            ACC1: begin
                acc     = 1'b1;
                state_d = RSP;
            end
`endif
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_we = acc & wr_q;
        if (acc && !wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    if (acc_hi) begin
                        rdata_d[32 + 8*i +: 8] = mem_rdata[8*i +: 8];
                    end else begin
                        rdata_d[8*i +: 8] = mem_rdata[8*i +: 8];
                    end
                end
            end
        end

        rsp_valid_d = (state_d == RSP);
        ready_d     = (state_d == IDLE);
        // Response payload is fixed when entering RSP and held until the next response.
        if (state_d == RSP) begin
            err_d  = bad_d;
            data_d = (bad_d || wr_d) ? 32'h0000_0000 : 32'(rdata_d >> {addr_d[1:0], 3'b000});
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            type_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bad_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bad_q       <= bad_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    // RAM is deliberately left without reset or initial contents.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign data_o      = data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp; expectations follow the DMEM_SPLIT_EN setting of the build.
module tb_dmem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_wr = 1'b0;
    logic [1:0]  rwtype = 2'b00;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] dout;
    logic        err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;
    logic [31:0] rd;
    logic        re;

    dmem_resp #(.ADDR_W(12)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .mem_wr_i    (mem_wr),
        .rwtype_i    (rwtype),
        .data_addr_i (addr),
        .data_i      (wdata),
        .rsp_valid_o (rsp_valid),
        .data_o      (dout),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One request; returns response latency in cycles after the accepting edge, or 99 if no response within 10 cycles.
    task automatic xact(input logic wr, input logic [1:0] t, input logic [11:0] a, input logic [31:0] d,
                        output int l, output logic [31:0] r, output logic e);
        @(negedge clk);
        req_valid = 1'b1; mem_wr = wr; rwtype = t; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_wr = ~wr; rwtype = 2'b11; addr = ~a; wdata = ~d;
        l = 99; r = 'x; e = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                l = i; r = dout; e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_chk++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", dout); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_aligned();
        xact(1'b1, 2'b10, 12'h010, 32'h1234_5678, lat, rd, re);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sw_lat: got %0d want 2", lat); end
        n_chk++; if (rd !== 32'h0 || re !== 1'b0) begin n_fail++; $display("FAIL sw_rsp: got %h/%b want 00000000/0", rd, re); end
        xact(1'b0, 2'b10, 12'h010, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 2 || rd !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_010: got %h lat %0d want 12345678 lat 2", rd, lat); end
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_seen: got %b want 1", rsp_valid); end
        @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse_width: got %b want 0", rsp_valid); end
        xact(1'b0, 2'b00, 12'h011, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 2 || rd !== 32'h0000_0056) begin n_fail++; $display("FAIL lb_011: got %h lat %0d want 00000056 lat 2", rd, lat); end
        xact(1'b0, 2'b01, 12'h012, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 2 || rd !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_012: got %h lat %0d want 00001234 lat 2", rd, lat); end
    endtask

    task automatic test_byte_merge();
        xact(1'b1, 2'b00, 12'h013, 32'h7777_77AB, lat, rd, re);
        n_chk++; if (lat !== 2 || rd !== 32'h0 || re !== 1'b0) begin n_fail++; $display("FAIL sb_rsp: got %h/%b lat %0d want 00000000/0 lat 2", rd, re, lat); end
        xact(1'b0, 2'b10, 12'h010, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'hAB34_5678) begin n_fail++; $display("FAIL merge_lw: got %h want ab345678", rd); end
        repeat (3) @(negedge clk);
        n_chk++; if (dout !== 32'hAB34_5678 || err !== 1'b0) begin n_fail++; $display("FAIL data_hold: got %h/%b want ab345678/0", dout, err); end
    endtask

    // Valid held high: the second accept only after RSP, so pulses land 3 cycles apart.
    task automatic test_back_to_back();
        logic [4:0] seen;
        seen = '0;
        @(negedge clk);
        req_valid = 1'b1; mem_wr = 1'b0; rwtype = 2'b00; addr = 12'h011; wdata = 32'h0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen[i] = rsp_valid;
        end
        req_valid = 1'b0;
        n_chk++; if (seen !== 5'b10010) begin n_fail++; $display("FAIL b2b_pattern: got %b want 10010", seen); end
        n_chk++; if (dout !== 32'h0000_0056) begin n_fail++; $display("FAIL b2b_data: got %h want 00000056", dout); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_split();
        xact(1'b1, 2'b10, 12'h00C, 32'h0, lat, rd, re);
        xact(1'b1, 2'b10, 12'h00E, 32'hAABB_CCDD, lat, rd, re);
`ifdef DMEM_SPLIT_EN
        n_chk++; if (lat !== 3 || re !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL split_sw: got %h/%b lat %0d want 00000000/0 lat 3", rd, re, lat); end
        xact(1'b0, 2'b10, 12'h00C, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'hCCDD_0000) begin n_fail++; $display("FAIL split_lo: got %h want ccdd0000", rd); end
        xact(1'b0, 2'b10, 12'h010, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'hAB34_AABB) begin n_fail++; $display("FAIL split_hi: got %h want ab34aabb", rd); end
        xact(1'b0, 2'b10, 12'h00E, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 3 || rd !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL split_lw: got %h lat %0d want aabbccdd lat 3", rd, lat); end
`else
        n_chk++; if (lat !== 1 || re !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_sw: got %h/%b lat %0d want 00000000/1 lat 1", rd, re, lat); end
        xact(1'b0, 2'b10, 12'h00C, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_lo: got %h want 00000000", rd); end
        xact(1'b0, 2'b10, 12'h010, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'hAB34_5678) begin n_fail++; $display("FAIL mis_hi: got %h want ab345678", rd); end
        xact(1'b0, 2'b10, 12'h00E, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 1 || re !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_lw: got %h/%b lat %0d want 00000000/1 lat 1", rd, re, lat); end
`endif
    endtask

    task automatic test_wrap();
        xact(1'b1, 2'b10, 12'hFFC, 32'h1122_3344, lat, rd, re);
        xact(1'b1, 2'b10, 12'h000, 32'h5566_7788, lat, rd, re);
        xact(1'b1, 2'b01, 12'hFFF, 32'h0000_BEEF, lat, rd, re);
`ifdef DMEM_SPLIT_EN
        n_chk++; if (lat !== 3 || re !== 1'b0) begin n_fail++; $display("FAIL wrap_sh: got err %b lat %0d want 0 lat 3", re, lat); end
        xact(1'b0, 2'b00, 12'hFFF, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h0000_00EF) begin n_fail++; $display("FAIL wrap_lb_fff: got %h want 000000ef", rd); end
        xact(1'b0, 2'b00, 12'h000, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h0000_00BE) begin n_fail++; $display("FAIL wrap_lb_000: got %h want 000000be", rd); end
        xact(1'b0, 2'b01, 12'hFFF, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 3 || rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL wrap_lh: got %h lat %0d want 0000beef lat 3", rd, lat); end
        xact(1'b0, 2'b10, 12'hFFC, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'hEF22_3344) begin n_fail++; $display("FAIL wrap_top: got %h want ef223344", rd); end
        xact(1'b0, 2'b10, 12'h000, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h5566_77BE) begin n_fail++; $display("FAIL wrap_bot: got %h want 556677be", rd); end
`else
        n_chk++; if (lat !== 1 || re !== 1'b1) begin n_fail++; $display("FAIL wrap_sh_err: got err %b lat %0d want 1 lat 1", re, lat); end
        xact(1'b0, 2'b10, 12'hFFC, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL wrap_top: got %h want 11223344", rd); end
        xact(1'b0, 2'b10, 12'h000, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h5566_7788) begin n_fail++; $display("FAIL wrap_bot: got %h want 55667788", rd); end
        xact(1'b0, 2'b01, 12'hFFF, 32'h0, lat, rd, re);
        n_chk++; if (lat !== 1 || re !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL wrap_lh_err: got %h/%b lat %0d want 00000000/1 lat 1", rd, re, lat); end
`endif
    endtask

    task automatic test_error_type();
        logic [31:0] exp_w10;
`ifdef DMEM_SPLIT_EN
        exp_w10 = 32'hAB34_AABB;
`else
        exp_w10 = 32'hAB34_5678;
`endif
        xact(1'b1, 2'b11, 12'h010, 32'hFFFF_FFFF, lat, rd, re);
        n_chk++; if (lat !== 1 || re !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL type11: got %h/%b lat %0d want 00000000/1 lat 1", rd, re, lat); end
        xact(1'b0, 2'b10, 12'h010, 32'h0, lat, rd, re);
        n_chk++; if (rd !== exp_w10 || re !== 1'b0) begin n_fail++; $display("FAIL type11_mem: got %h/%b want %h/0", rd, re, exp_w10); end
    endtask

    task automatic test_reset_abort();
        logic saw;
        xact(1'b1, 2'b10, 12'h01C, 32'h0, lat, rd, re);
        xact(1'b1, 2'b10, 12'h020, 32'h0, lat, rd, re);
        @(negedge clk);
        req_valid = 1'b1; mem_wr = 1'b1; rwtype = 2'b10; wdata = 32'hDEAD_BEEF;
`ifdef DMEM_SPLIT_EN
        addr = 12'h01E;
`else
        addr = 12'h01C;
`endif
        @(posedge clk);
        #1 req_valid = 1'b0;
`ifdef DMEM_SPLIT_EN
        @(posedge clk);
        #1;
`endif
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) saw = 1'b1;
        end
        n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got %b want 0", saw); end
        xact(1'b0, 2'b10, 12'h01C, 32'h0, lat, rd, re);
`ifdef DMEM_SPLIT_EN
        n_chk++; if (rd !== 32'hBEEF_0000) begin n_fail++; $display("FAIL abort_lo: got %h want beef0000", rd); end
`else
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h want 00000000", rd); end
`endif
        xact(1'b0, 2'b10, 12'h020, 32'h0, lat, rd, re);
        n_chk++; if (rd !== 32'h0 || lat !== 2) begin n_fail++; $display("FAIL abort_hi: got %h lat %0d want 00000000 lat 2", rd, lat); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_byte_merge();
        test_back_to_back();
        test_split();
        test_wrap();
        test_error_type();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
